// File: rtl/s_axis_pixel_window_pkg.sv
// s_axis_pixel_window_pkg: shared stream FSM encodings and default pixel geometry
package s_axis_pixel_window_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DISCARD} state_t;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_PIX_W = 24;
  localparam int DEF_WIN_N = 3;
  localparam int DEF_LINE_PIX = 32;
  localparam int DEF_FRAME_PIX = 960;
endpackage

// File: rtl/s_axis_pixel_window_shift.sv
// s_axis_pixel_window_shift: WIN_N-deep pixel shift register with per-line fill tracking
module s_axis_pixel_window_shift #(
  parameter int PIX_W = 24,
  parameter int WIN_N = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic                   line_clr,
  input  logic [PIX_W-1:0]       pix,
  output logic [WIN_N*PIX_W-1:0] win,
  output logic                   complete
);
  localparam int FW = $clog2(WIN_N + 1);
  logic [PIX_W-1:0] w [WIN_N];
  logic [FW-1:0] fill;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fill <= '0;
      for (int i = 0; i < WIN_N; i++) w[i] <= '0;
    end else begin
      if (clr) fill <= '0;
      else if (shift_en) fill <= line_clr ? '0 : (fill == FW'(WIN_N) ? fill : fill + 1'b1);
      if (shift_en) begin
        w[0] <= pix;
        for (int i = 1; i < WIN_N; i++) w[i] <= w[i-1];
      end
    end
  end
  for (genvar i = 0; i < WIN_N; i++) begin : g_pack
    assign win[i*PIX_W +: PIX_W] = w[i];
  end
  assign complete = fill >= FW'(WIN_N - 1);
endmodule

// File: rtl/s_axis_pixel_window.sv
// s_axis_pixel_window: AXI4-Stream pixel slave emitting per-line sliding windows with tlast checks
module s_axis_pixel_window
  import s_axis_pixel_window_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PIX_W = DEF_PIX_W,
  parameter int WIN_N = DEF_WIN_N,
  parameter int LINE_PIX = DEF_LINE_PIX,
  parameter int FRAME_PIX = DEF_FRAME_PIX
) (
  input  logic                   clk,
  input  logic                   rstn,
  output logic                   s_axis_tready,
  input  logic [DATA_W-1:0]      s_axis_tdata,
  input  logic [DATA_W/8-1:0]    s_axis_tstrb,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  input  logic                   m_ready,
  output logic                   out_valid,
  output logic [WIN_N*PIX_W-1:0] out_data,
  output logic                   out_last,
  output logic                   err_early_last,
  output logic                   err_late_last
);
  localparam int CW = $clog2(LINE_PIX);
  localparam int PW = $clog2(FRAME_PIX);
  state_t state, state_nxt;
  logic [CW-1:0] col;
  logic [PW-1:0] pix;
  logic accept, run_acc, col_end, frame_end, complete, unused_ok;
  assign unused_ok = &{1'b0, s_axis_tstrb, s_axis_tdata};
  assign s_axis_tready = state == DISCARD || (state == RUN && (!out_valid || m_ready));
  assign accept = s_axis_tvalid && s_axis_tready;
  assign run_acc = accept && state == RUN;
  assign col_end = col == CW'(LINE_PIX - 1);
  assign frame_end = pix == PW'(FRAME_PIX - 1);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = s_axis_tvalid ? RUN : IDLE;
      RUN:     state_nxt = run_acc && (s_axis_tlast || frame_end) ? (s_axis_tlast ? FLUSH : DISCARD) : RUN;
      FLUSH:   state_nxt = !out_valid || m_ready ? IDLE : FLUSH;
      DISCARD: state_nxt = accept && s_axis_tlast ? IDLE : DISCARD;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      col <= '0;
      pix <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      err_early_last <= 1'b0;
      err_late_last <= 1'b0;
    end else begin
      state <= state_nxt;
      err_early_last <= run_acc && s_axis_tlast && !frame_end;
      err_late_last <= run_acc && frame_end && !s_axis_tlast;
      if (state == IDLE) begin
        col <= '0;
        pix <= '0;
      end else if (run_acc) begin
        col <= col_end ? '0 : col + 1'b1;
        pix <= pix + 1'b1;
      end
      if (run_acc && complete) begin
        out_valid <= 1'b1;
        out_last <= s_axis_tlast || frame_end;
      end else if (m_ready) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end
  // The shift register doubles as the output register: it only moves on an accepted beat,
  // and no beat is accepted while a window is stalled.
  s_axis_pixel_window_shift #(.PIX_W(PIX_W), .WIN_N(WIN_N)) u_shift (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (state == IDLE),
    .shift_en (run_acc),
    .line_clr (col_end),
    .pix      (s_axis_tdata[PIX_W-1:0]),
    .win      (out_data),
    .complete (complete)
  );
endmodule
